// File: rtl/ld_str_mem_ctrl_pkg.sv
// rtl/ld_str_mem_ctrl_pkg.sv - shared widths and state encoding for the load/store memory stage
package ld_str_mem_ctrl_pkg;

  localparam int unsigned N_DEF       = 8;
  localparam int unsigned AW_DEF      = 8;
  localparam int unsigned TIMEOUT_DEF = 15;

  // 2'b11 is unused; the next-state logic sends it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

endpackage

// File: rtl/ld_str_mem_ctrl_wait_cnt.sv
// rtl/ld_str_mem_ctrl_wait_cnt.sv - wait-state counter with clear, enable and terminal-count flag
//
// Ports:
//   clk      rising-edge clock
//   clr      asynchronous active-low reset
//   clear_i  synchronous clear to zero (takes priority over en_i)
//   en_i     increment enable
//   tc_o     high while the count equals TIMEOUT-1
module ld_str_wait_cnt #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ld_str_mem_ctrl.sv
// rtl/ld_str_mem_ctrl.sv - load/store memory-access stage with req/ack port, wait-state timeout and stall
//
// Ports:
//   clk, clr                          clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake from the load/store operand stage
//   req_we/req_addr/req_wdata         request fields (1 = store)
//   mem_req/mem_we/mem_addr/mem_wdata memory request, held for the whole ISSUE state
//   mem_ack/mem_rdata                 memory completion pulse and load data
//   rsp_valid/rsp_rdata/rsp_err       one-cycle completion pulse, result, timeout flag
//   stall                             pipeline hold while a transaction is outstanding
module ld_str_mem_ctrl
  import ld_str_mem_ctrl_pkg::*;
#(
  parameter int unsigned N       = N_DEF,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [N-1:0]  req_wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic          mem_ack,
  input  logic [N-1:0]  mem_rdata,
  output logic          rsp_valid,
  output logic [N-1:0]  rsp_rdata,
  output logic          rsp_err,
  output logic          stall
);

  state_e        state_q, state_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [N-1:0]  wdata_q;
  logic [N-1:0]  rdata_q;
  logic          err_q;
  logic          tc;
  logic          accept;

  assign accept = (state_q == ST_IDLE) && req_valid;

  // The counter stops advancing on the terminal cycle, so it can never wrap.
  ld_str_wait_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_cnt (
    .clk     (clk),
    .clr     (clr),
    .clear_i (accept),
    .en_i    ((state_q == ST_ISSUE) && !mem_ack && !tc),
    .tc_o    (tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_ISSUE;
      ST_ISSUE: if (mem_ack || tc) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An ack on the terminal cycle is checked first, so it counts as success.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == ST_ISSUE) begin
        if (mem_ack) begin
          rdata_q <= we_q ? '0 : mem_rdata;
          err_q   <= 1'b0;
        end else if (tc) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign stall     = (state_q != ST_IDLE);
  assign mem_req   = (state_q == ST_ISSUE);
  assign rsp_valid = (state_q == ST_RESP);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_ld_str_mem_ctrl.sv
// tb/tb_ld_str_mem_ctrl.sv - scoreboard testbench for ld_str_mem_ctrl
module tb_ld_str_mem_ctrl;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       stall;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ld_str_mem_ctrl dut (
    .clk       (clk),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .stall     (stall)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (clr && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
  end

  // Called at a negedge with the DUT in IDLE. ack_at = ISSUE cycle carrying the ack;
  // values beyond TO mean the memory never answers.
  task automatic do_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        input int ack_at, input logic [7:0] rd, input bit hold);
    int   len;
    exp_t e;
    len     = (ack_at <= TO) ? ack_at : TO;
    e.err   = (ack_at > TO);
    e.rdata = (e.err || we) ? 8'h00 : rd;
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (!hold) begin
        req_valid = 1'b0;
        req_addr  = $urandom;
      end
      chk("mem_req_issue", {31'd0, mem_req}, 32'd1);
      chk("mem_we", {31'd0, mem_we}, {31'd0, we});
      chk("mem_addr", {24'd0, mem_addr}, {24'd0, addr});
      chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, wdata});
      chk("stall_issue", {31'd0, stall}, 32'd1);
      chk("ready_issue", {31'd0, req_ready}, 32'd0);
      mem_ack   = (k == ack_at);
      mem_rdata = (k == ack_at) ? rd : 8'($urandom);
    end
    exp_q.push_back(e);
    @(negedge clk);
    mem_ack   = 1'b0;
    req_valid = 1'b0;
    chk("mem_req_resp", {31'd0, mem_req}, 32'd0);
    chk("rsp_valid_resp", {31'd0, rsp_valid}, 32'd1);
    chk("stall_resp", {31'd0, stall}, 32'd1);
    @(negedge clk);
    chk("ready_after", {31'd0, req_ready}, 32'd1);
    chk("stall_after", {31'd0, stall}, 32'd0);
    chk("rsp_valid_single", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_outs", {6'd0, mem_we, mem_addr, mem_wdata, rsp_rdata, rsp_err}, 32'd0);
    clr = 1'b1;
    @(negedge clk);

    // Directed: load ack in 2nd cycle, store ack in 1st, timeout, ack on timeout cycle
    do_txn(1'b0, 8'h3C, 8'h00, 2, 8'hA5, 1'b0);
    do_txn(1'b1, 8'h10, 8'h5A, 1, 8'h77, 1'b0);
    do_txn(1'b0, 8'h20, 8'h00, TO + 3, 8'h33, 1'b0);
    do_txn(1'b0, 8'h21, 8'h00, TO, 8'hFF, 1'b0);

    // Reset mid-ISSUE abandons the transaction
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 8'h44;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    chk("mid_mem_req", {31'd0, mem_req}, 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_ready", {31'd0, req_ready}, 32'd1);
    chk("async_stall", {31'd0, stall}, 32'd0);
    chk("async_addr", {24'd0, mem_addr}, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("post_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    do_txn(1'b0, 8'h55, 8'h00, 3, 8'hC3, 1'b0);

    // Stray ack in IDLE, then a request held through ISSUE
    mem_ack   = 1'b1;
    mem_rdata = 8'hEE;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack_ready", {31'd0, req_ready}, 32'd1);
    chk("stray_ack_rsp", {31'd0, rsp_valid}, 32'd0);
    do_txn(1'b0, 8'h66, 8'h00, 4, 8'h9B, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        mem_ack   = ($urandom_range(0, 1) == 1);
        mem_rdata = 8'($urandom);
        @(negedge clk);
        mem_ack = 1'b0;
      end
      do_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
             $urandom_range(1, TO + 3), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
